// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Purpose  : Shared types and constants for the pipeline hazard / exception
//             controller: exception sequencer state encoding, exception
//             class encoding with its priority selector, cause codes and
//             default exception vector.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Exception sequencer states: detect happens in IDLE, then two cycles of
  // drain/redirect before the pipeline runs again.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  // Exception class of the instruction currently in EX.
  typedef enum logic [2:0] {
    EXC_NONE = 3'd0,
    EXC_SYS  = 3'd1,
    EXC_RI   = 3'd2,
    EXC_ERET = 3'd3,
    EXC_INT  = 3'd4
  } exc_class_e;

  localparam logic [31:0] EXC_VECTOR_DEF    = 32'h0000_0180;
  localparam int unsigned CR_HAZ_CYCLES_DEF = 2;
  localparam logic [4:0]  CAUSE_SYS_DEF     = 5'd8;
  localparam logic [4:0]  CAUSE_RI_DEF      = 5'd10;
  localparam logic [4:0]  CAUSE_INT_DEF     = 5'd0;

  // Fixed priority: syscall > RI > eret > interrupt. Several exception bits
  // together is illegal upstream but still resolves deterministically.
  function automatic exc_class_e exc_select(input logic sys,
                                            input logic ri,
                                            input logic eret,
                                            input logic irq);
    exc_class_e cls;
    if (sys)       cls = EXC_SYS;
    else if (ri)   cls = EXC_RI;
    else if (eret) cls = EXC_ERET;
    else if (irq)  cls = EXC_INT;
    else           cls = EXC_NONE;
    return cls;
  endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/exc_seq_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : exc_seq_fsm
//  Purpose  : Three-step exception / eret sequencer (IDLE -> DRAIN ->
//             REDIRECT -> IDLE). Owns the state register and the latched
//             redirect target, and produces the EPC/Cause write pulse.
//  Ports    : clk, reset (async active-low)
//             syscall/ri/eret/irq  - exception requests, sampled in IDLE only
//             pcplus4, epc         - PC+4 of EX instruction, current CP0 EPC
//             busy, exc_detect     - sequence active / detect cycle
//             irq_ack              - interrupt accepted this cycle
//             if_id_flush, id_ex_flush, ex_mem_flush, pc_stall
//             pc_redirect, redirect_pc
//             epc_write, epc_data, cause_code
//  Revision : 1.0 - initial release
// ============================================================================
module exc_seq_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [4:0]  CAUSE_SYS  = CAUSE_SYS_DEF,
  parameter logic [4:0]  CAUSE_RI   = CAUSE_RI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall,
  input  logic        ri,
  input  logic        eret,
  input  logic        irq,
  input  logic [31:0] pcplus4,
  input  logic [31:0] epc,
  output logic        busy,
  output logic        exc_detect,
  output logic        irq_ack,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        pc_stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        epc_write,
  output logic [31:0] epc_data,
  output logic [4:0]  cause_code
);

  exc_state_e  state_q, state_d;
  logic [31:0] redirect_q, redirect_d;
  exc_class_e  exc_cls;

  always_comb begin
    exc_cls      = exc_select(syscall, ri, eret, irq);
    state_d      = state_q;
    redirect_d   = redirect_q;
    busy         = 1'b0;
    exc_detect   = 1'b0;
    irq_ack      = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_stall     = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = '0;
    epc_write    = 1'b0;
    epc_data     = '0;
    cause_code   = '0;

    case (state_q)
      ST_IDLE: begin
        if (exc_cls != EXC_NONE) begin
          exc_detect   = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          state_d      = ST_DRAIN;
          // eret target is latched now so a later EPC update cannot move it.
          redirect_d   = (exc_cls == EXC_ERET) ? epc : EXC_VECTOR;
          irq_ack      = (exc_cls == EXC_INT);
          if (exc_cls != EXC_ERET) begin
            epc_write = 1'b1;
            epc_data  = pcplus4 - 32'd4;
            case (exc_cls)
              EXC_SYS: cause_code = CAUSE_SYS;
              EXC_RI:  cause_code = CAUSE_RI;
              default: cause_code = CAUSE_INT_DEF;
            endcase
          end
        end
      end
      ST_DRAIN: begin
        busy        = 1'b1;
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        busy        = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = redirect_q;
        if_id_flush = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

endmodule : exc_seq_fsm
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Pipeline hazard / exception controller. Generates load-use
//             and CP0 read-after-write bubbles, branch squash, and (through
//             exc_seq_fsm) the exception / eret redirect sequence.
//  Config   : HAZ_EXT_INT_EN - adds Ext_Int input with a 2-flop synchronizer
//             and pending-interrupt latch; undefined = no interrupt source.
//  Ports    : clk, reset (async active-low; all outputs forced 0 while low)
//             ID_rs/ID_rt/ID_use_rs/ID_use_rt/ID_CR_Read - ID operand info
//             ID_EX_* - EX instruction info (load, dest, CP0 write, exc class,
//             PC+4), EX_Branch_Taken, EPC
//             PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
//             EX_MEM_Flush, PC_Redirect, Redirect_PC, EPC_Write, EPC_data,
//             Cause_code, Busy
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
  parameter int unsigned CR_HAZ_CYCLES = CR_HAZ_CYCLES_DEF,
  parameter logic [4:0]  CAUSE_SYS     = CAUSE_SYS_DEF,
  parameter logic [4:0]  CAUSE_RI      = CAUSE_RI_DEF
) (
  input  logic        clk,
  input  logic        reset,
`ifdef HAZ_EXT_INT_EN
  input  logic        Ext_Int,
`endif
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic        ID_CR_Read,
  input  logic        ID_EX_MemRead_data,
  input  logic [4:0]  ID_EX_rt,
  input  logic        ID_EX_CR_Write_data,
  input  logic        ID_EX_syscall_data,
  input  logic        ID_EX_eret_data,
  input  logic        ID_EX_RI_data,
  input  logic [31:0] ID_EX_PCplus4_data,
  input  logic        EX_Branch_Taken,
  input  logic [31:0] EPC,
  output logic        PC_Stall,
  output logic        IF_ID_Stall,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Stall,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic        PC_Redirect,
  output logic [31:0] Redirect_PC,
  output logic        EPC_Write,
  output logic [31:0] EPC_data,
  output logic [4:0]  Cause_code,
  output logic        Busy
);

  localparam int CR_CNT_W = (CR_HAZ_CYCLES > 0) ? $clog2(CR_HAZ_CYCLES + 1) : 1;

  // --------------------------------------------------------------------------
  // Interrupt source
  // --------------------------------------------------------------------------
  logic irq;
  logic irq_ack;

`ifdef HAZ_EXT_INT_EN
  // [0],[1] synchronize Ext_Int; [2] holds the previous synchronized level
  // for rising-edge detection.
  logic [2:0] int_sync_q, int_sync_d;
  logic       irq_pend_q, irq_pend_d;

  always_comb begin
    int_sync_d = {int_sync_q[1:0], Ext_Int};
    irq_pend_d = irq_pend_q;
    if (irq_ack)
      irq_pend_d = 1'b0;
    // A fresh edge in the acknowledge cycle is a new request, keep it.
    if (int_sync_q[1] && !int_sync_q[2])
      irq_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_sync_q <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      int_sync_q <= int_sync_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq = irq_pend_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Exception sequencer
  // --------------------------------------------------------------------------
  logic        fsm_busy, fsm_detect;
  logic        fsm_if_id_flush, fsm_id_ex_flush, fsm_ex_mem_flush, fsm_pc_stall;
  logic        fsm_pc_redirect, fsm_epc_write;
  logic [31:0] fsm_redirect_pc, fsm_epc_data;
  logic [4:0]  fsm_cause_code;

  exc_seq_fsm #(
    .EXC_VECTOR (EXC_VECTOR),
    .CAUSE_SYS  (CAUSE_SYS),
    .CAUSE_RI   (CAUSE_RI)
  ) u_exc_seq_fsm (
    .clk          (clk),
    .reset        (reset),
    .syscall      (ID_EX_syscall_data),
    .ri           (ID_EX_RI_data),
    .eret         (ID_EX_eret_data),
    .irq          (irq),
    .pcplus4      (ID_EX_PCplus4_data),
    .epc          (EPC),
    .busy         (fsm_busy),
    .exc_detect   (fsm_detect),
    .irq_ack      (irq_ack),
    .if_id_flush  (fsm_if_id_flush),
    .id_ex_flush  (fsm_id_ex_flush),
    .ex_mem_flush (fsm_ex_mem_flush),
    .pc_stall     (fsm_pc_stall),
    .pc_redirect  (fsm_pc_redirect),
    .redirect_pc  (fsm_redirect_pc),
    .epc_write    (fsm_epc_write),
    .epc_data     (fsm_epc_data),
    .cause_code   (fsm_cause_code)
  );

  // --------------------------------------------------------------------------
  // CP0 read-after-write window counter
  // --------------------------------------------------------------------------
  logic [CR_CNT_W-1:0] cr_cnt_q, cr_cnt_d;

  always_comb begin
    cr_cnt_d = cr_cnt_q;
    if (ID_EX_CR_Write_data)
      cr_cnt_d = CR_CNT_W'(CR_HAZ_CYCLES);
    else if (cr_cnt_q != '0)
      cr_cnt_d = cr_cnt_q - CR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cr_cnt_q <= '0;
    else        cr_cnt_q <= cr_cnt_d;
  end

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic load_use, cr_hazard, hazard_stall, seq_active;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ID_EX_MemRead_data && (ID_EX_rt != 5'd0) &&
                    ((ID_use_rs && (ID_rs == ID_EX_rt)) ||
                     (ID_use_rt && (ID_rt == ID_EX_rt)));

  assign cr_hazard    = ID_CR_Read && (ID_EX_CR_Write_data || (cr_cnt_q != '0));
  assign hazard_stall = load_use || cr_hazard;

  // Detect cycle counts as active so branch/stall controls cannot mix in.
  assign seq_active = fsm_busy || fsm_detect;

  // --------------------------------------------------------------------------
  // Output merge
  // --------------------------------------------------------------------------
  always_comb begin
    PC_Stall     = fsm_pc_stall;
    IF_ID_Stall  = 1'b0;
    IF_ID_Flush  = fsm_if_id_flush;
    ID_EX_Stall  = 1'b0;   // reserved for a multicycle EX stage
    ID_EX_Flush  = fsm_id_ex_flush;
    EX_MEM_Flush = fsm_ex_mem_flush;
    PC_Redirect  = fsm_pc_redirect;
    Redirect_PC  = fsm_redirect_pc;
    EPC_Write    = fsm_epc_write;
    EPC_data     = fsm_epc_data;
    Cause_code   = fsm_cause_code;
    Busy         = fsm_busy;

    if (!seq_active) begin
      if (EX_Branch_Taken) begin
        // Squash wrong-path instructions; a stall would only delay that.
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else if (hazard_stall) begin
        // Hold PC and IF/ID, insert a bubble into ID/EX.
        PC_Stall    = 1'b1;
        IF_ID_Stall = 1'b1;
        ID_EX_Flush = 1'b1;
      end
    end

    if (!reset) begin
      PC_Stall     = 1'b0;
      IF_ID_Stall  = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Stall  = 1'b0;
      ID_EX_Flush  = 1'b0;
      EX_MEM_Flush = 1'b0;
      PC_Redirect  = 1'b0;
      Redirect_PC  = '0;
      EPC_Write    = 1'b0;
      EPC_data     = '0;
      Cause_code   = '0;
      Busy         = 1'b0;
    end
  end

endmodule : pipe_hazard_ctrl
`default_nettype wire
